// File: rtl/fft_stage_sequencer_pkg.sv
// Shared constants, state encoding, the write-context struct and a digit helper
// for the radix-4 N=4096 FFT stage sequencer.
// Optional feature macro: FFT_SCALE_EN (adds the scale strobe to the bus).
package fft_stage_sequencer_pkg;

  localparam int N      = 4096;
  localparam int A_BIT  = 10;               // bank address width, N/4 words per bank
  localparam int STAGES = 6;                // log4(N)
  localparam int C_BIT  = $clog2(N / 4);    // butterfly counter width
  localparam int TW_BIT = $clog2(N);        // twiddle exponent width

  // Sequencer states: IDLE, RUN, DRAIN, NEXT, DONE
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // One entry of the read-to-write delay pipe; sel is already the RAM to write.
  typedef struct packed {
    logic                  valid;
    logic [3:0][A_BIT-1:0] addr;
    logic [1:0]            rot;
    logic                  sel;
  } wr_ctx_t;

  // Sum of the base-4 digits of v, mod 4: the bank of an element in the memory map.
  function automatic logic [1:0] digit_sum_mod4(input logic [C_BIT-1:0] v);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 0; i < C_BIT / 2; i++) s = s + v[2*i +: 2];
    return s;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Sequencer bus: start request plus the read/write address streams to the RAMs,
// data mixer and butterfly. With FFT_SCALE_EN the scale strobe is present.
//
// Handshake: start is a one-cycle request with no back-pressure; it is acted on
// only when the sequencer is idle or done, otherwise dropped. rd_valid qualifies
// rd_addr_*/rd_rot/tw_idx in the same cycle, we qualifies wr_addr_*/wr_rot/wr_sel
// in the same cycle; the RAMs always accept, so there is no ready signal.
interface fft_stage_sequencer_if;
  import fft_stage_sequencer_pkg::*;

  logic              start;
  logic              busy;
  logic              rdy;
  logic [2:0]        stage;
  logic              rd_sel;
  logic [A_BIT-1:0]  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
  logic [1:0]        rd_rot;
  logic              rd_valid;
  logic [TW_BIT-1:0] tw_idx;
  logic              we;
  logic              wr_sel;
  logic [A_BIT-1:0]  wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3;
  logic [1:0]        wr_rot;
  logic [2:0]        dbg_state;
`ifdef FFT_SCALE_EN
  logic              scale;
`endif

  modport master (
    input  start,
    output busy, rdy, stage, rd_sel, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
    output rd_rot, rd_valid, tw_idx, we, wr_sel,
    output wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3, wr_rot, dbg_state
`ifdef FFT_SCALE_EN
    , output scale
`endif
  );

  modport slave (
    output start,
    input  busy, rdy, stage, rd_sel, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
    input  rd_rot, rd_valid, tw_idx, we, wr_sel,
    input  wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3, wr_rot, dbg_state
`ifdef FFT_SCALE_EN
    , input scale
`endif
  );

endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// fft_addr_gen: combinational (stage, butterfly counter) -> per-bank addresses,
// bank rotation and twiddle base exponent. Leg p is the counter with base-4
// digit (5-stage) inserted as p; it lands in bank (rot+p) mod 4.
module fft_addr_gen
  import fft_stage_sequencer_pkg::*;
(
  input  logic [2:0]            stage,
  input  logic [C_BIT-1:0]      cnt,
  output logic [3:0][A_BIT-1:0] addr,
  output logic [1:0]            rot,
  output logic [TW_BIT-1:0]     tw_idx
);

  logic [3:0]        sh;        // bit position of the inserted digit
  logic [TW_BIT-1:0] c_ext;
  logic [TW_BIT-1:0] lo_mask;   // digits below the inserted one
  logic [TW_BIT-1:0] hi_part;   // digits above, moved up by one digit

  // Split the counter around the inserted digit; twiddle from the low digits.
  always_comb begin
    sh      = {3'(3'd5 - stage), 1'b0};
    c_ext   = {{(TW_BIT-C_BIT){1'b0}}, cnt};
    lo_mask = (TW_BIT'(1) << sh) - TW_BIT'(1);
    hi_part = (c_ext >> sh) << (sh + 4'd2);
    rot     = digit_sum_mod4(cnt);
    tw_idx  = (c_ext & lo_mask) << {stage, 1'b0};
  end

  // Bank b holds leg p = (b - rot) mod 4; its address is the low A_BIT bits.
  always_comb begin
    logic [1:0] leg;
    leg  = 2'd0;
    addr = '0;
    for (int b = 0; b < 4; b++) begin
      leg     = 2'(b) - rot;
      addr[b] = A_BIT'(hi_part | ({{(TW_BIT-2){1'b0}}, leg} << sh) | (c_ext & lo_mask));
    end
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: steps the 6 radix-4 stages over the ping-pong RAMs,
// issuing one butterfly read per cycle and replaying it to the write side
// LAT cycles later. Optional macro FFT_SCALE_EN adds the scale strobe.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int LAT = 4   // read-to-write latency, 2..15
)(
  input  logic                  iCLK,
  input  logic                  iRESET,
  fft_stage_sequencer_if.master bus
);

  logic [2:0]            state;
  logic [2:0]            stage;
  logic [C_BIT-1:0]      cnt;
  logic [3:0]            dcnt;
  logic                  rd_valid;
  logic [3:0][A_BIT-1:0] gen_addr;
  logic [1:0]            gen_rot;
  logic [TW_BIT-1:0]     gen_tw;
  wr_ctx_t               rd_ctx;
  wr_ctx_t               pipe [LAT];

  fft_addr_gen u_addr_gen (
    .stage  (stage),
    .cnt    (cnt),
    .addr   (gen_addr),
    .rot    (gen_rot),
    .tw_idx (gen_tw)
  );

  assign rd_valid = (state == ST_RUN);

  // Stage FSM: RUN 1024 butterflies, DRAIN LAT cycles, one NEXT gap, then DONE.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= ST_IDLE;
      stage <= 3'd0;
      cnt   <= '0;
      dcnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state <= ST_RUN;
            stage <= 3'd0;
            cnt   <= '0;
            dcnt  <= 4'd0;
          end
        end
        ST_RUN: begin
          if (cnt == C_BIT'(N / 4 - 1)) begin
            state <= ST_DRAIN;
            dcnt  <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dcnt == 4'(LAT - 1)) state <= ST_NEXT;
          else                     dcnt  <= dcnt + 4'd1;
        end
        ST_NEXT: begin
          cnt <= '0;
          if (stage < 3'(STAGES - 1)) begin
            stage <= stage + 3'd1;
            state <= ST_RUN;
          end else begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Context of this cycle's read, with the write RAM select already flipped.
  always_comb begin
    rd_ctx       = '0;
    rd_ctx.valid = rd_valid;
    if (rd_valid) begin
      rd_ctx.addr = gen_addr;
      rd_ctx.rot  = gen_rot;
      rd_ctx.sel  = ~stage[0];
    end
  end

  // Delay pipe replaying each read to the write side LAT cycles later.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_ctx;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.busy      = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_NEXT);
  assign bus.rdy       = (state == ST_DONE);
  assign bus.stage     = stage;
  assign bus.rd_sel    = stage[0];
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_addr_0 = rd_ctx.addr[0];
  assign bus.rd_addr_1 = rd_ctx.addr[1];
  assign bus.rd_addr_2 = rd_ctx.addr[2];
  assign bus.rd_addr_3 = rd_ctx.addr[3];
  assign bus.rd_rot    = rd_ctx.rot;
  assign bus.tw_idx    = rd_valid ? gen_tw : '0;
  assign bus.we        = pipe[LAT-1].valid;
  assign bus.wr_sel    = pipe[LAT-1].sel;
  assign bus.wr_addr_0 = pipe[LAT-1].addr[0];
  assign bus.wr_addr_1 = pipe[LAT-1].addr[1];
  assign bus.wr_addr_2 = pipe[LAT-1].addr[2];
  assign bus.wr_addr_3 = pipe[LAT-1].addr[3];
  assign bus.wr_rot    = pipe[LAT-1].rot;
  assign bus.dbg_state = state;
`ifdef FFT_SCALE_EN
  assign bus.scale     = pipe[LAT-1].valid;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: arithmetic model of the stage schedule and the
// radix-4 memory map, per-cycle compare, plus hand-computed directed checks.
// Honours FFT_SCALE_EN when defined.
module tb_fft_stage_sequencer;

  localparam int LAT = 4;
  localparam int SC  = 1024 + LAT + 1;   // cycles per stage

  typedef struct packed {
    logic            valid;
    logic [3:0][9:0] addr;
    logic [1:0]      rot;
    logic            sel;
    logic [11:0]     tw;
  } rd_t;
  localparam int W = $bits(rd_t);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_sequencer_if bus ();

  fft_stage_sequencer #(.LAT(LAT)) dut (
    .iCLK   (clk),
    .iRESET (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  function automatic int digsum(input int x);
    int s;
    s = 0;
    for (int v = x; v > 0; v = v / 4) s += v % 4;
    return s;
  endfunction

  // Butterfly (s, c): four legs, each placed in the bank given by its own digit sum.
  function automatic rd_t model_rd(input int s, input int c);
    rd_t r;
    int  pos, p4, lo, hi, n;
    r     = '0;
    pos   = 5 - s;
    p4    = 4 ** pos;
    lo    = c % p4;
    hi    = c / p4;
    for (int p = 0; p < 4; p++) begin
      n = hi * p4 * 4 + p * p4 + lo;
      r.addr[digsum(n) % 4] = 10'(n % 1024);
    end
    r.valid = 1'b1;
    r.rot   = 2'(digsum(c) % 4);
    r.sel   = 1'(s % 2);
    r.tw    = 12'(lo * (4 ** s));
    return r;
  endfunction

  logic m_run = 1'b0;
  logic m_rdy = 1'b0;
  int   m_t   = 0;
  logic [W-1:0] exp_q[$];

  function automatic int model_stage();
    if (m_run) return m_t / SC;
    return m_rdy ? 5 : 0;
  endfunction

  function automatic rd_t model_cycle();
    rd_t r;
    r = '0;
    if (m_run && (m_t % SC) < 1024) r = model_rd(m_t / SC, m_t % SC);
    else                            r.sel = 1'(model_stage() % 2);
    return r;
  endfunction

  // Model advance; exp_q holds the reads of the last LAT cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_rdy <= 1'b0;
      m_t   <= 0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_cycle());
      void'(exp_q.pop_front());
      if (m_run) begin
        if (m_t == 6 * SC - 1) begin
          m_run <= 1'b0;
          m_rdy <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (bus.start) begin
        m_run <= 1'b1;
        m_rdy <= 1'b0;
        m_t   <= 0;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    rd_t e, w;
    if (exp_q.size() == LAT) begin
      e = model_cycle();
      w = exp_q[0];
      chk("busy",     bus.busy,     m_run);
      chk("rdy",      bus.rdy,      m_rdy);
      chk("stage",    bus.stage,    model_stage());
      chk("rd_valid", bus.rd_valid, e.valid);
      chk("rd_sel",   bus.rd_sel,   e.sel);
      if (e.valid) begin
        chk("rd_addr_0", bus.rd_addr_0, e.addr[0]);
        chk("rd_addr_1", bus.rd_addr_1, e.addr[1]);
        chk("rd_addr_2", bus.rd_addr_2, e.addr[2]);
        chk("rd_addr_3", bus.rd_addr_3, e.addr[3]);
        chk("rd_rot",    bus.rd_rot,    e.rot);
        chk("tw_idx",    bus.tw_idx,    e.tw);
      end
      chk("we", bus.we, w.valid);
`ifdef FFT_SCALE_EN
      chk("scale", bus.scale, w.valid);
`endif
      if (w.valid) begin
        chk("wr_addr_0", bus.wr_addr_0, w.addr[0]);
        chk("wr_addr_1", bus.wr_addr_1, w.addr[1]);
        chk("wr_addr_2", bus.wr_addr_2, w.addr[2]);
        chk("wr_addr_3", bus.wr_addr_3, w.addr[3]);
        chk("wr_rot",    bus.wr_rot,    w.rot);
        chk("wr_sel",    bus.wr_sel,    !w.sel);
      end
    end
    if (rst_n && bus.we) we_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   bus.busy,      0);
    chk({tag, "_rdy"},    bus.rdy,       0);
    chk({tag, "_stage"},  bus.stage,     0);
    chk({tag, "_rdsel"},  bus.rd_sel,    0);
    chk({tag, "_rdv"},    bus.rd_valid,  0);
    chk({tag, "_rda0"},   bus.rd_addr_0, 0);
    chk({tag, "_rda1"},   bus.rd_addr_1, 0);
    chk({tag, "_rda2"},   bus.rd_addr_2, 0);
    chk({tag, "_rda3"},   bus.rd_addr_3, 0);
    chk({tag, "_rdrot"},  bus.rd_rot,    0);
    chk({tag, "_tw"},     bus.tw_idx,    0);
    chk({tag, "_we"},     bus.we,        0);
    chk({tag, "_wrsel"},  bus.wr_sel,    0);
    chk({tag, "_wra0"},   bus.wr_addr_0, 0);
    chk({tag, "_wra1"},   bus.wr_addr_1, 0);
    chk({tag, "_wra2"},   bus.wr_addr_2, 0);
    chk({tag, "_wra3"},   bus.wr_addr_3, 0);
    chk({tag, "_wrrot"},  bus.wr_rot,    0);
    chk({tag, "_state"},  bus.dbg_state, 0);
`ifdef FFT_SCALE_EN
    chk({tag, "_scale"},  bus.scale,     0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rd_t r;
    int  base;
    bus.start = 1'b0;

    wait_cyc(3);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Pin the model with hand-computed butterflies.
    r = model_rd(0, 5);
    chk("model_s0_a0", r.addr[0], 5);
    chk("model_s0_a3", r.addr[3], 5);
    chk("model_s0_rot", r.rot, 2);
    chk("model_s0_tw", r.tw, 5);
    r = model_rd(1, 255);
    chk("model_s1_a0", r.addr[0], 10'h0FF);
    chk("model_s1_a1", r.addr[1], 10'h1FF);
    chk("model_s1_a2", r.addr[2], 10'h2FF);
    chk("model_s1_a3", r.addr[3], 10'h3FF);
    chk("model_s1_tw", r.tw, 12'h3FC);

    // Run 1: start at cycle 10, busy at 11.
    wait_cyc(10);
    base = we_cnt;
    chk("busy_pre_start", bus.busy, 0);
    bus.start = 1'b1;
    wait_cyc(11);
    bus.start = 1'b0;
    chk("busy_at_11", bus.busy, 1);
    chk("rd_valid_at_11", bus.rd_valid, 1);

    wait_cyc(16);   // stage 0, c=5
    chk("s0c5_a0", bus.rd_addr_0, 5);
    chk("s0c5_a1", bus.rd_addr_1, 5);
    chk("s0c5_a2", bus.rd_addr_2, 5);
    chk("s0c5_a3", bus.rd_addr_3, 5);
    chk("s0c5_rot", bus.rd_rot, 2);
    chk("s0c5_tw", bus.tw_idx, 5);
    chk("s0c5_sel", bus.rd_sel, 0);

    wait_cyc(20);   // write of stage 0, c=5
    chk("s0c5_we", bus.we, 1);
    chk("s0c5_wa0", bus.wr_addr_0, 5);
    chk("s0c5_wa3", bus.wr_addr_3, 5);
    chk("s0c5_wrot", bus.wr_rot, 2);
    chk("s0c5_wsel", bus.wr_sel, 1);

    wait_cyc(1038); // last write of stage 0 (c=1023)
    chk("s0_last_we", bus.we, 1);
    chk("s0_last_wa2", bus.wr_addr_2, 1023);
    chk("s0_last_wrot", bus.wr_rot, 3);
    wait_cyc(1039); // NEXT gap
    chk("next_rd_valid", bus.rd_valid, 0);
    chk("next_we", bus.we, 0);
    chk("next_busy", bus.busy, 1);
    wait_cyc(1040);
    chk("s1_start_stage", bus.stage, 1);

    wait_cyc(1295); // stage 1, c=0x0FF
    chk("s1_stage", bus.stage, 1);
    chk("s1_a0", bus.rd_addr_0, 10'h0FF);
    chk("s1_a1", bus.rd_addr_1, 10'h1FF);
    chk("s1_a2", bus.rd_addr_2, 10'h2FF);
    chk("s1_a3", bus.rd_addr_3, 10'h3FF);
    chk("s1_rot", bus.rd_rot, 0);
    chk("s1_sel", bus.rd_sel, 1);
    chk("s1_tw", bus.tw_idx, 12'h3FC);

    // Stray start in stage 2 must be ignored.
    wait_cyc(2369);
    bus.start = 1'b1;
    wait_cyc(2370); // stage 2, c=301
    bus.start = 1'b0;
    chk("s2_stage", bus.stage, 2);
    chk("s2_a0", bus.rd_addr_0, 109);
    chk("s2_a1", bus.rd_addr_1, 173);
    chk("s2_a2", bus.rd_addr_2, 237);
    chk("s2_a3", bus.rd_addr_3, 45);
    chk("s2_rot", bus.rd_rot, 3);
    chk("s2_tw", bus.tw_idx, 720);

    wait_cyc(6184);
    chk("rdy_before_done", bus.rdy, 0);
    chk("stage_last", bus.stage, 5);
    wait_cyc(6185);
    chk("rdy_at_done", bus.rdy, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("we_count_run1", we_cnt - base, 6144);

    // Restart from DONE.
    wait_cyc(6190);
    chk("rdy_hold", bus.rdy, 1);
    bus.start = 1'b1;
    wait_cyc(6191);
    bus.start = 1'b0;
    chk("restart_rdy", bus.rdy, 0);
    chk("restart_busy", bus.busy, 1);
    chk("restart_stage", bus.stage, 0);
    chk("restart_rd_valid", bus.rd_valid, 1);

    // Asynchronous reset in the middle of stage 3.
    wait_cyc(9778);
    chk("pre_reset_stage", bus.stage, 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    wait_cyc(9781);
    #2 rst_n = 1'b1;
    for (int k = 9782; k <= 9790; k++) begin
      wait_cyc(k);
      chk("we_after_reset", bus.we, 0);
    end

    // Fresh run after reset.
    wait_cyc(9800);
    base = we_cnt;
    bus.start = 1'b1;
    wait_cyc(9801);
    bus.start = 1'b0;
    chk("run3_busy", bus.busy, 1);
    wait_cyc(9801 + 6 * SC - 1);
    chk("run3_rdy_before", bus.rdy, 0);
    wait_cyc(9801 + 6 * SC);
    chk("run3_rdy", bus.rdy, 1);
    chk("we_count_run3", we_cnt - base, 6144);

    wait_cyc(9801 + 6 * SC + 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence ends near 160k time units.
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout, expected finish (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
